// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo: synchronous valid/ready stream FIFO with first-word fall-through.
//
// Parameters
//   DATA_W : payload width in bits
//   DEPTH  : number of storage entries (power of two, >= 2)
//   CNT_W  : width of the completed-output-transfer counter
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : upstream word present
//   in_ready  : block accepts a word this cycle
//   in_data   : upstream payload
//   out_valid : head word present
//   out_ready : downstream accepts the head word
//   out_data  : head payload (oldest stored word)
//   level     : current occupancy, 0..DEPTH
//   xfer_cnt  : count of completed output transfers, wraps naturally
module leaf_stream_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         xfer_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    // Ready comes only from registered occupancy (and reset), never from out_ready,
    // so a full FIFO being drained reopens one cycle later.
    assign in_ready  = !rst && (level < FULL_LEVEL);
    // No bypass: a word is only visible once it has been stored.
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    // Control state; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            xfer_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + 1'b1;
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; wr_en is already low while rst is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Self-checking bench for leaf_stream_fifo: a queue scoreboard filled by the
// driver and drained by an independent negedge monitor, plus directed checks.
module tb_leaf_stream_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        level;
    logic [CNT_W-1:0]  xfer_cnt;

    // Second instance with a narrow counter for the wrap scenario.
    logic              rst2;
    logic              in_valid2;
    logic              in_ready2;
    logic [DATA_W-1:0] in_data2;
    logic              out_valid2;
    logic              out_ready2;
    logic [DATA_W-1:0] out_data2;
    logic [2:0]        level2;
    logic [3:0]        xfer_cnt2;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  exp_cnt;
    logic              mon_en = 1'b0;
    logic              acc_pend = 1'b0;
    logic              rst_pend = 1'b0;
    logic [DATA_W-1:0] data_pend = '0;

    always #5 clk = ~clk;

    leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .xfer_cnt(xfer_cnt)
    );

    leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .level(level2), .xfer_cnt(xfer_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive inputs for the coming edge and decide what the model expects to happen.
    task automatic set_in(input logic v, input logic [DATA_W-1:0] d, input logic r,
                          input logic rs);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        rst       = rs;
        acc_pend  = v && !rs && (exp_q.size() < DEPTH);
        rst_pend  = rs;
        data_pend = d;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_pend) begin
            exp_q.delete();
            exp_cnt = '0;
        end else if (acc_pend) begin
            exp_q.push_back(data_pend);
        end
        #1;
    endtask

    // Monitor: compares observable state against the scoreboard every cycle and
    // pops the expected head when a read is about to complete.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                chk("mon_in_ready_rst", 32'(in_ready), 32'd0);
            end else begin
                chk("mon_level", 32'(level), 32'(exp_q.size()));
                chk("mon_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
                chk("mon_in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
                chk("mon_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_read", 32'd1, 32'd0);
                    end else begin
                        chk("mon_out_data", 32'(out_data), 32'(exp_q.pop_front()));
                        exp_cnt = exp_cnt + 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_cnt    = '0;
        rst2       = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        rst2 = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word.
        set_in(1'b1, 8'hA5, 1'b0, 1'b0);
        tick();
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'hA5);
        chk("single_level", 32'(level), 32'd1);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk("single_level_after", 32'(level), 32'd0);
        chk("single_xfer_cnt", 32'(xfer_cnt), 32'd1);

        // Fill, stall a fifth word, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 8'h05, 1'b0, 1'b0);
            tick();
            chk("stall_level", 32'(level), 32'd4);
        end
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_out_data", 32'(out_data), 32'(i));
            tick();
        end
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_xfer_cnt", 32'(xfer_cnt), 32'd5);

        // Full edge: read completes, write of 0x15 is refused.
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 8'h15, 1'b1, 1'b0);
        chk("full_edge_in_ready_same", 32'(in_ready), 32'd0);
        tick();
        chk("full_edge_level", 32'(level), 32'd3);
        chk("full_edge_in_ready_next", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        chk("full_edge_drained", 32'(level), 32'd0);

        // Streaming from a fresh reset.
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 100; i++) begin
            set_in(1'b1, 8'(i), 1'b1, 1'b0);
            tick();
            if (i > 0) begin
                chk("stream_level", 32'(level), 32'd1);
            end
        end
        chk("stream_xfer_cnt", 32'(xfer_cnt), 32'd99);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk("stream_tail_level", 32'(level), 32'd0);

        // Reset mid-stream with a handshake pending on the reset edge.
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            tick();
        end
        chk("midrst_level_before", 32'(level), 32'd3);
        set_in(1'b1, 8'h34, 1'b1, 1'b1);
        tick();
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        set_in(1'b1, 8'h7E, 1'b0, 1'b0);
        tick();
        chk("midrst_first_word", 32'(out_data), 32'h7E);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk("midrst_xfer_after", 32'(xfer_cnt), 32'd1);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);

        // Counter wrap on the 4-bit instance: 17 cycles give 16 reads, 18 give 17.
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data2 = 8'(i);
            @(posedge clk);
            #1;
        end
        chk("wrap_cnt_16_reads", 32'(xfer_cnt2), 32'd0);
        @(posedge clk);
        #1;
        chk("wrap_cnt_17_reads", 32'(xfer_cnt2), 32'd1);
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;

        tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
